// File: rtl/distance_sq_pipe.sv
// Iterative squared-Euclidean / Manhattan distance between a query and a vertex.
// Optional L1 mode selectable via mode_in when DISTANCE_L1_MODE_EN is defined.
module distance_sq_pipe #(
  parameter int DIM   = 2,
  parameter int WIDTH = 32
) (
  input  logic                        clk_in,
  input  logic                        rst_n_in,
  input  logic                        valid_in,
  output logic                        ready_in,
  input  logic [DIM-1:0][WIDTH-1:0]   vertex_pos_in,
  input  logic [DIM-1:0][WIDTH-1:0]   query_pos_in,
  input  logic                        mode_in,
  output logic [2*WIDTH+$clog2(DIM+1)-1:0] distance_out,
  output logic                        valid_out,
  input  logic                        ready_out
);

  localparam int OW = 2*WIDTH + $clog2(DIM+1);
  localparam int IW = $clog2(DIM+1);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] ACCUM = 2'd1;
  localparam logic [1:0] DONE  = 2'd2;

  localparam logic [IW-1:0] LAST_IDX = IW'(DIM);

  logic [1:0]                state;
  logic [DIM-1:0][WIDTH-1:0] vertex_reg;
  logic [DIM-1:0][WIDTH-1:0] query_reg;
  logic [OW-1:0]             acc;
  logic [IW-1:0]             idx;
  logic [2*WIDTH-1:0]        term_reg;
  logic [2*WIDTH-1:0]        term;
  logic [2*WIDTH-1:0]        diff_ext;
  logic [WIDTH-1:0]          sel_v;
  logic [WIDTH-1:0]          sel_q;
  logic [WIDTH-1:0]          abs_diff;
  logic [OW-1:0]             acc_next;
  logic                      accept;

`ifdef DISTANCE_L1_MODE_EN
  logic mode_reg;
`else
  logic unused_mode;
  assign unused_mode = mode_in;
`endif

  assign ready_in = (state == IDLE);
  assign accept   = valid_in && ready_in;
  assign acc_next = acc + {{(OW-2*WIDTH){1'b0}}, term_reg};

  // Term for the current index; registered one cycle later so the squarer
  // and the accumulator adder sit in separate stages.
  always_comb begin
    sel_v = '0;
    sel_q = '0;
    for (int i = 0; i < DIM; i++) begin
      if (idx == IW'(i)) begin
        sel_v = vertex_reg[i];
        sel_q = query_reg[i];
      end
    end
    abs_diff = (sel_v >= sel_q) ? (sel_v - sel_q) : (sel_q - sel_v);
    diff_ext = {{WIDTH{1'b0}}, abs_diff};
`ifdef DISTANCE_L1_MODE_EN
    term = mode_reg ? diff_ext : (diff_ext * diff_ext);
`else
    term = diff_ext * diff_ext;
`endif
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state        <= IDLE;
      valid_out    <= 1'b0;
      distance_out <= '0;
      acc          <= '0;
      idx          <= '0;
      term_reg     <= '0;
      vertex_reg   <= '0;
      query_reg    <= '0;
`ifdef DISTANCE_L1_MODE_EN
      mode_reg     <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            vertex_reg <= vertex_pos_in;
            query_reg  <= query_pos_in;
`ifdef DISTANCE_L1_MODE_EN
            mode_reg   <= mode_in;
`endif
            acc        <= '0;
            idx        <= '0;
            term_reg   <= '0;
            state      <= ACCUM;
          end
        end
        ACCUM: begin
          acc      <= acc_next;
          term_reg <= term;
          // idx runs one past the last dimension to drain the term register
          if (idx == LAST_IDX) begin
            distance_out <= acc_next;
            valid_out    <= 1'b1;
            state        <= DONE;
          end else begin
            idx <= idx + IW'(1);
          end
        end
        DONE: begin
          if (ready_out) begin
            valid_out <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
